// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and byte-to-word address helper for systolic_mem_arbiter.
//   req_id_t : requester identity carried with each in-flight read
//   tag_t    : {valid, id} entry of the read-return tag pipe
//   byte_to_word : byte address to memory-word address (before truncation to AW)
package mem_arb_pkg;

    typedef enum logic [1:0] {REQ_NONE, REQ_W, REQ_X, REQ_WR} req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    function automatic logic [31:0] byte_to_word(input logic [31:0] addr, input int unsigned sh);
        return addr >> sh;
    endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// mem_arb_tag_pipe: LAT-deep shift register of read tags, matching the SRAM read latency.
//   clk, srstn : clock, asynchronous active-low reset (clears every stage)
//   tag_i      : tag issued with this cycle's grant
//   tag_o      : tag leaving the last stage, aligned with sram_rdata
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic srstn,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [LAT];

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_o = pipe_q[LAT-1];

endmodule

// File: rtl/systolic_mem_arbiter.sv
// systolic_mem_arbiter: shares one single-port SRAM between W reads, X reads and result writes.
//   clk, srstn                         : clock, asynchronous active-low reset
//   mem_read_w/w_addr -> w_gnt/w_rvalid/w_rdata : W read stream
//   mem_read_x/x_addr -> x_gnt/x_rvalid/x_rdata : X read stream
//   mem_write/mem_write_addr/mem_wdata -> wr_gnt : write stream
//   sram_en/sram_we/sram_addr/sram_wdata, sram_rdata : physical SRAM port
// Optional MEM_ARB_STATS_EN adds saturating 32-bit counters stat_w_cnt, stat_x_cnt,
// stat_wr_cnt (grants) and stat_stall_cnt (cycles with an ungranted request).
module systolic_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int ARRAY_ROWS   = 4,
    parameter  int MEM_DEPTH    = 64,
    parameter  int MEM_LAT      = 1,
    parameter  int STARVE_LIMIT = 8,
    localparam int WW           = DATA_WIDTH * ARRAY_ROWS,
    localparam int AW           = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          srstn,
    input  logic          mem_read_w,
    input  logic [31:0]   w_addr,
    output logic          w_gnt,
    output logic          w_rvalid,
    output logic [WW-1:0] w_rdata,
    input  logic          mem_read_x,
    input  logic [31:0]   x_addr,
    output logic          x_gnt,
    output logic          x_rvalid,
    output logic [WW-1:0] x_rdata,
    input  logic          mem_write,
    input  logic [31:0]   mem_write_addr,
    input  logic [WW-1:0] mem_wdata,
    output logic          wr_gnt,
    output logic          sram_en,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [WW-1:0] sram_wdata,
    input  logic [WW-1:0] sram_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_w_cnt,
    output logic [31:0]   stat_x_cnt,
    output logic [31:0]   stat_wr_cnt,
    output logic [31:0]   stat_stall_cnt
`endif
);

    localparam int SH  = $clog2(WW / 8);
    localparam int AGW = ($clog2(STARVE_LIMIT + 1) > 4) ? $clog2(STARVE_LIMIT + 1) : 4;
    localparam logic [AGW-1:0] LIM = AGW'(STARVE_LIMIT);

    logic [AGW-1:0] w_age_q, w_age_d, x_age_q, x_age_d;
    logic           rr_ptr_q, rr_ptr_d;
    logic           w_req, x_req, wr_req, w_st, x_st, any_st;
    logic [31:0]    sel_addr;
    tag_t           tag_in, tag_out;

    always_comb begin
        // Requests are masked during reset so every output reads zero.
        w_req  = mem_read_w & srstn;
        x_req  = mem_read_x & srstn;
        wr_req = mem_write & srstn;
        w_st   = w_req && (w_age_q >= LIM);
        x_st   = x_req && (x_age_q >= LIM);
        any_st = w_st | x_st;
        // rr_ptr_q: 0 prefers W, 1 prefers X. A starved reader outranks the write.
        w_gnt  = any_st ? (w_st && (!x_st || !rr_ptr_q))
                        : (!wr_req && w_req && (!x_req || !rr_ptr_q));
        x_gnt  = any_st ? (x_st && !w_gnt) : (!wr_req && x_req && !w_gnt);
        wr_gnt = wr_req && !any_st;
        sram_en    = w_gnt | x_gnt | wr_gnt;
        sram_we    = wr_gnt;
        sel_addr   = wr_gnt ? mem_write_addr : w_gnt ? w_addr : x_gnt ? x_addr : '0;
        sram_addr  = AW'(byte_to_word(sel_addr, SH));
        sram_wdata = wr_gnt ? mem_wdata : '0;
        w_rdata    = srstn ? sram_rdata : '0;
        x_rdata    = srstn ? sram_rdata : '0;
        w_age_d  = (!w_req || w_gnt) ? '0 : (&w_age_q ? w_age_q : w_age_q + 1'b1);
        x_age_d  = (!x_req || x_gnt) ? '0 : (&x_age_q ? x_age_q : x_age_q + 1'b1);
        // Point at the reader that did not just get served.
        rr_ptr_d = w_gnt ? 1'b1 : x_gnt ? 1'b0 : rr_ptr_q;
        tag_in.valid = w_gnt | x_gnt;
        tag_in.id    = w_gnt ? REQ_W : x_gnt ? REQ_X : REQ_NONE;
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            w_age_q  <= '0;
            x_age_q  <= '0;
            rr_ptr_q <= 1'b0;
        end else begin
            w_age_q  <= w_age_d;
            x_age_q  <= x_age_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    mem_arb_tag_pipe #(.LAT(MEM_LAT)) u_tag_pipe (
        .clk   (clk),
        .srstn (srstn),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign w_rvalid = tag_out.valid && (tag_out.id == REQ_W);
    assign x_rvalid = tag_out.valid && (tag_out.id == REQ_X);

`ifdef MEM_ARB_STATS_EN
    logic [31:0] st_w_q, st_x_q, st_wr_q, st_stall_q;
    logic        stall;

    assign stall = (w_req & ~w_gnt) | (x_req & ~x_gnt) | (wr_req & ~wr_gnt);

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            st_w_q     <= '0;
            st_x_q     <= '0;
            st_wr_q    <= '0;
            st_stall_q <= '0;
        end else begin
            st_w_q     <= st_w_q     + {31'b0, w_gnt  & ~&st_w_q};
            st_x_q     <= st_x_q     + {31'b0, x_gnt  & ~&st_x_q};
            st_wr_q    <= st_wr_q    + {31'b0, wr_gnt & ~&st_wr_q};
            st_stall_q <= st_stall_q + {31'b0, stall  & ~&st_stall_q};
        end
    end

    assign stat_w_cnt     = st_w_q;
    assign stat_x_cnt     = st_x_q;
    assign stat_wr_cnt    = st_wr_q;
    assign stat_stall_cnt = st_stall_q;
`endif

endmodule

// File: tb/tb_systolic_mem_arbiter.sv
// tb_systolic_mem_arbiter: directed and randomized checks of systolic_mem_arbiter against
// a priority-list model with an expected-return queue and a shadow memory.
module tb_systolic_mem_arbiter;

    localparam int LAT = 3;
    localparam int SL  = 8;
    localparam int WW  = 128;
    localparam int AW  = 6;

    logic          clk = 1'b0;
    logic          srstn;
    logic          mem_read_w, mem_read_x, mem_write;
    logic [31:0]   w_addr, x_addr, mem_write_addr;
    logic [WW-1:0] mem_wdata;
    logic          w_gnt, x_gnt, wr_gnt, w_rvalid, x_rvalid, sram_en, sram_we;
    logic [WW-1:0] w_rdata, x_rdata, sram_wdata, sram_rdata;
    logic [AW-1:0] sram_addr;

    always #5 clk = ~clk;

    systolic_mem_arbiter #(.MEM_LAT(LAT), .STARVE_LIMIT(SL)) dut (
        .clk            (clk),
        .srstn          (srstn),
        .mem_read_w     (mem_read_w),
        .w_addr         (w_addr),
        .w_gnt          (w_gnt),
        .w_rvalid       (w_rvalid),
        .w_rdata        (w_rdata),
        .mem_read_x     (mem_read_x),
        .x_addr         (x_addr),
        .x_gnt          (x_gnt),
        .x_rvalid       (x_rvalid),
        .x_rdata        (x_rdata),
        .mem_write      (mem_write),
        .mem_write_addr (mem_write_addr),
        .mem_wdata      (mem_wdata),
        .wr_gnt         (wr_gnt),
        .sram_en        (sram_en),
        .sram_we        (sram_we),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata)
    );

    function automatic logic [WW-1:0] init_word(int i);
        return (i == 2) ? 128'hA : {4{32'hC0DE0000 + 32'(i)}};
    endfunction

    // SRAM behavioural model: refilled with known contents while reset is low.
    logic [WW-1:0] mem [64];
    logic [WW-1:0] rp [LAT];

    always @(posedge clk) begin
        if (!srstn) for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        else if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
        rp[0] <= (sram_en && !sram_we) ? mem[sram_addr] : '0;
        for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end

    assign sram_rdata = rp[LAT-1];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: grant chosen from an explicit priority list each cycle.
    typedef struct {
        int            due;
        int            id;
        logic [WW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    ret_t          r;
    logic [WW-1:0] shadow [64];
    int            m_wage, m_xage, m_ptr, cyc, e, widx;
    bit            ws, xs, ew, ex;
    logic [31:0]   ea;

    always @(negedge clk) begin
        if (!srstn) begin
            m_wage = 0;
            m_xage = 0;
            m_ptr  = 0;
            rq.delete();
            for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
            chk("m_rst_gnt",   {w_gnt, x_gnt, wr_gnt}, 0);
            chk("m_rst_rv",    {w_rvalid, x_rvalid}, 0);
            chk("m_rst_en",    {sram_en, sram_we}, 0);
            chk("m_rst_addr",  sram_addr, 0);
            chk("m_rst_wdata", sram_wdata, 0);
            chk("m_rst_wrd",   w_rdata, 0);
            chk("m_rst_xrd",   x_rdata, 0);
        end else begin
            ws = mem_read_w && m_wage >= SL;
            xs = mem_read_x && m_xage >= SL;
            if (ws && xs)                     e = (m_ptr == 0) ? 1 : 2;
            else if (ws)                      e = 1;
            else if (xs)                      e = 2;
            else if (mem_write)               e = 3;
            else if (mem_read_w && mem_read_x) e = (m_ptr == 0) ? 1 : 2;
            else if (mem_read_w)              e = 1;
            else if (mem_read_x)              e = 2;
            else                              e = 0;
            chk("m_w_gnt",  w_gnt,  e == 1);
            chk("m_x_gnt",  x_gnt,  e == 2);
            chk("m_wr_gnt", wr_gnt, e == 3);
            chk("m_en",     sram_en, e != 0);
            chk("m_we",     sram_we, e == 3);
            ea   = (e == 3) ? mem_write_addr : (e == 1) ? w_addr : (e == 2) ? x_addr : 32'h0;
            widx = int'(ea >> 4) % 64;
            chk("m_addr",  sram_addr, widx);
            chk("m_wdata", sram_wdata, (e == 3) ? mem_wdata : '0);
            ew = rq.size() > 0 && rq[0].due == cyc && rq[0].id == 1;
            ex = rq.size() > 0 && rq[0].due == cyc && rq[0].id == 2;
            chk("m_w_rvalid", w_rvalid, ew);
            chk("m_x_rvalid", x_rvalid, ex);
            if (ew) chk("m_w_rdata", w_rdata, rq[0].data);
            if (ex) chk("m_x_rdata", x_rdata, rq[0].data);
            if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
            if (e == 1 || e == 2) begin
                r.due  = cyc + LAT;
                r.id   = e;
                r.data = shadow[widx];
                rq.push_back(r);
            end
            if (e == 3) shadow[widx] = mem_wdata;
            m_wage = (!mem_read_w || e == 1) ? 0 : (m_wage < 15 ? m_wage + 1 : 15);
            m_xage = (!mem_read_x || e == 2) ? 0 : (m_xage < 15 ? m_xage + 1 : 15);
            if (e == 1) m_ptr = 1;
            if (e == 2) m_ptr = 0;
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        srstn = 1'b0;
        step();
        step();
        srstn = 1'b1;
    endtask

    bit wg, xg, rg;
    int wr_pct;

    initial begin
        srstn = 1'b0;
        mem_read_w = 1'b1; w_addr = 32'h20;
        mem_read_x = 1'b1; x_addr = 32'h40;
        mem_write = 1'b1; mem_write_addr = 32'h30; mem_wdata = '1;
        @(negedge clk);
        chk("rst_grants", {w_gnt, x_gnt, wr_gnt}, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        step();
        step();
        mem_read_w = 1'b0; mem_read_x = 1'b0; mem_write = 1'b0;
        srstn = 1'b1;

        // Single W read of word 2.
        step();
        mem_read_w = 1'b1; w_addr = 32'h20;
        @(negedge clk);
        chk("t1_w_gnt", w_gnt, 1);
        chk("t1_addr", sram_addr, 2);
        step();
        mem_read_w = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("t1_w_rvalid", w_rvalid, k == LAT);
            chk("t1_x_rvalid", x_rvalid, 0);
            if (k == LAT) chk("t1_w_rdata", w_rdata, 128'hA);
        end

        // Alternating reads after reset.
        do_reset();
        mem_read_w = 1'b1; w_addr = 32'h100;
        mem_read_x = 1'b1; x_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_w_gnt", w_gnt, i % 2 == 0);
            chk("t2_x_gnt", x_gnt, i % 2 == 1);
        end
        step();
        mem_read_w = 1'b0; mem_read_x = 1'b0;

        // Starvation: write held with a pending W read.
        step();
        mem_write = 1'b1; mem_write_addr = 32'h400; mem_wdata = 128'h1234;
        mem_read_w = 1'b1; w_addr = 32'h10;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("t3_wr_gnt", wr_gnt, i < 9);
            chk("t3_w_gnt", w_gnt, i == 9);
        end
        step();
        mem_read_w = 1'b0;
        @(negedge clk);
        chk("t3_wr_resume", wr_gnt, 1);
        step();
        mem_write = 1'b0;

        // Write then read back word 3.
        step();
        mem_write = 1'b1; mem_write_addr = 32'h30; mem_wdata = 128'h5;
        @(negedge clk);
        chk("t4_we", {wr_gnt, sram_we}, 2'b11);
        chk("t4_addr", sram_addr, 3);
        chk("t4_wdata", sram_wdata, 128'h5);
        step();
        mem_write = 1'b0;
        mem_read_w = 1'b1; w_addr = 32'h30;
        @(negedge clk);
        chk("t4_w_gnt", w_gnt, 1);
        step();
        mem_read_w = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("t4_w_rvalid", w_rvalid, k == LAT);
            if (k == LAT) chk("t4_w_rdata", w_rdata, 128'h5);
        end

        // Reset while an X read is in flight.
        step();
        mem_read_x = 1'b1; x_addr = 32'h50;
        @(negedge clk);
        chk("t5_x_gnt", x_gnt, 1);
        step();
        mem_read_x = 1'b0; srstn = 1'b0;
        mem_read_w = 1'b1; w_addr = 32'h70;
        mem_write = 1'b1; mem_write_addr = 32'h70;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t5_rst_rvalid", {w_rvalid, x_rvalid}, 0);
            chk("t5_rst_gnt", {w_gnt, x_gnt, wr_gnt}, 0);
            chk("t5_rst_en", sram_en, 0);
            chk("t5_rst_addr", sram_addr, 0);
            chk("t5_rst_xrdata", x_rdata, 0);
            if (k == 0) step();
        end
        step();
        mem_read_w = 1'b0; mem_write = 1'b0; srstn = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            chk("t5_no_x_rvalid", x_rvalid, 0);
        end

        // Randomized traffic; requests are held until granted except for rare drops.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            wg = w_gnt; xg = x_gnt; rg = wr_gnt;
            step();
            wr_pct = ((c / 300) % 2 == 1) ? 95 : 40;
            if (!srstn) srstn = 1'b1;
            else if ($urandom_range(0, 399) == 0) srstn = 1'b0;
            if (!(mem_read_w && !wg && $urandom_range(0, 15) != 0)) begin
                mem_read_w = $urandom_range(0, 3) != 0;
                w_addr = $urandom;
            end
            if (!(mem_read_x && !xg && $urandom_range(0, 15) != 0)) begin
                mem_read_x = $urandom_range(0, 3) != 0;
                x_addr = $urandom;
            end
            if (!(mem_write && !rg && $urandom_range(0, 15) != 0)) begin
                mem_write = $urandom_range(0, 99) < wr_pct;
                mem_write_addr = $urandom;
                mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        mem_read_w = 1'b0; mem_read_x = 1'b0; mem_write = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
